// File: rtl/svm_dskw_pkg.sv
// Shared types and defaults for the SVM AXI-Stream to BRAM writer.
// Holds the FSM state enum, parameter defaults and the BRAM write-enable constant.
package svm_dskw_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    localparam int DEF_WIDTH       = 16;
    localparam int DEF_TDATA_WIDTH = 32;
    localparam int DEF_DEPTH       = 1024;
    localparam int DEF_ADDR_STEP   = 4;

    localparam logic [3:0] BRAM_WE_ALL = 4'b1111;

endpackage

// File: rtl/svm_axis_bram_writer.sv
// Unpacks AXI-Stream beats into WIDTH-bit words written one per cycle into BRAM.
// Optional tlast/length consistency checking is enabled by SVM_TLAST_CHECK_EN.
module svm_axis_bram_writer
    import svm_dskw_pkg::*;
#(
    parameter int WIDTH                = DEF_WIDTH,
    parameter int C_S_AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
    parameter int DEPTH                = DEF_DEPTH,
    parameter int ADDR_STEP            = DEF_ADDR_STEP,
    parameter int CNT_W                = $clog2(DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [31:0]                     base_addr,
    input  logic [CNT_W-1:0]                length,
    output logic                            busy,
    output logic                            err,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [31:0]                     axi_address,
    output logic [WIDTH-1:0]                axi_in_data,
    output logic                            axi_en,
    output logic [3:0]                      axi_we,
    output logic                            done_interrupt
);

    localparam int LANES = C_S_AXIS_TDATA_WIDTH / WIDTH;
    localparam int LW    = $clog2(LANES + 1);

    state_t state_q, state_d;

    logic                            busy_q, busy_d;
    logic                            err_q, err_d;
    logic                            tready_q, tready_d;
    logic                            en_q, en_d;
    logic [3:0]                      we_q, we_d;
    logic [31:0]                     addr_q, addr_d;
    logic [WIDTH-1:0]                data_q, data_d;
    logic                            done_q, done_d;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]                len_q, len_d;
    logic [CNT_W-1:0]                idx_q, idx_d;
    logic [LW-1:0]                   lane_q, lane_d;
    logic [31:0]                     nxt_addr_q, nxt_addr_d;
    logic                            early_q, early_d;

    logic [WIDTH-1:0] lane_word;

    always_comb begin
        lane_word = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_q == LW'(i)) begin
                lane_word = hold_q[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef SVM_TLAST_CHECK_EN
    logic [CNT_W-1:0] remain;
    logic             final_beat;

    // The beat about to be captured holds word length-1.
    assign remain     = len_q - idx_q;
    assign final_beat = (remain <= CNT_W'(LANES));
`else
    logic tlast_unused;

    assign tlast_unused = s_axis_tlast;
`endif

    always_comb begin
        state_d    = state_q;
        busy_d     = 1'b1;
        err_d      = err_q;
        tready_d   = 1'b0;
        en_d       = 1'b0;
        we_d       = '0;
        addr_d     = addr_q;
        data_d     = data_q;
        done_d     = 1'b0;
        hold_d     = hold_q;
        len_d      = len_q;
        idx_d      = idx_q;
        lane_d     = lane_q;
        nxt_addr_d = nxt_addr_q;
        early_d    = early_q;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                    len_d      = length;
                    idx_d      = '0;
                    lane_d     = '0;
                    nxt_addr_d = base_addr;
                    early_d    = 1'b0;
                    if (length == '0) begin
                        state_d = DONE;
                    end else if (length > CNT_W'(DEPTH)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d  = RECV;
                        tready_d = 1'b1;
                    end
                end
            end

            RECV: begin
                tready_d = 1'b1;
                if (s_axis_tvalid) begin
                    // Lane 0 goes out straight from the bus on the accepting edge.
                    tready_d   = 1'b0;
                    hold_d     = s_axis_tdata;
                    en_d       = 1'b1;
                    we_d       = BRAM_WE_ALL;
                    data_d     = s_axis_tdata[WIDTH-1:0];
                    addr_d     = nxt_addr_q;
                    nxt_addr_d = nxt_addr_q + 32'(ADDR_STEP);
                    idx_d      = idx_q + CNT_W'(1);
                    lane_d     = LW'(1);
                    state_d    = WRITE;
`ifdef SVM_TLAST_CHECK_EN
                    if (s_axis_tlast != final_beat) begin
                        err_d = 1'b1;
                    end
                    early_d = s_axis_tlast && !final_beat;
`else
                    early_d = 1'b0;
`endif
                end
            end

            WRITE: begin
                if (idx_q == len_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (lane_q == LW'(LANES)) begin
                    if (early_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = RECV;
                        tready_d = 1'b1;
                    end
                end else begin
                    en_d       = 1'b1;
                    we_d       = BRAM_WE_ALL;
                    data_d     = lane_word;
                    addr_d     = nxt_addr_q;
                    nxt_addr_d = nxt_addr_q + 32'(ADDR_STEP);
                    idx_d      = idx_q + CNT_W'(1);
                    lane_d     = lane_q + LW'(1);
                end
            end

            DONE: begin
                // Zero-length and rejected transfers spend one quiet cycle here first.
                if (done_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    done_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            tready_q   <= 1'b0;
            en_q       <= 1'b0;
            we_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            hold_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            lane_q     <= '0;
            nxt_addr_q <= '0;
            early_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            tready_q   <= tready_d;
            en_q       <= en_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            done_q     <= done_d;
            hold_q     <= hold_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            lane_q     <= lane_d;
            nxt_addr_q <= nxt_addr_d;
            early_q    <= early_d;
        end
    end

    assign busy           = busy_q;
    assign err            = err_q;
    assign s_axis_tready  = tready_q;
    assign axi_address    = addr_q;
    assign axi_in_data    = data_q;
    assign axi_en         = en_q;
    assign axi_we         = we_q;
    assign done_interrupt = done_q;

endmodule
